// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MIO bus initiator.
// MEM_SUBWORD_EN enables half/byte accesses (RMW_RD state and lane logic).
package mem_bus_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        ERR,
        DONE
`ifdef MEM_SUBWORD_EN
        ,
        RMW_RD
`endif
    } state_t;

endpackage

// File: rtl/mem_bus_if.sv
// Request/response handshake plus MIO bus signals of the CPU-side initiator.
interface mem_bus_if;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] addr_bus;
    logic [31:0] Cpu_data2bus;
    logic        mem_w;
    logic [31:0] Cpu_data4bus;

    modport master (
        input  req, we, size, uns, addr, wdata, Cpu_data4bus,
        output rdata, busy, done, misalign, addr_bus, Cpu_data2bus, mem_w
    );

    modport slave (
        output req, we, size, uns, addr, wdata, Cpu_data4bus,
        input  rdata, busy, done, misalign, addr_bus, Cpu_data2bus, mem_w
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for
// read-modify-write stores. Purely combinational; used under MEM_SUBWORD_EN.
module mem_lane_align
    import mem_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    function automatic logic [31:0] ext8(input logic [7:0] v, input logic zx);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = v;
        w = s;
        return zx ? {24'b0, v} : w;
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] v, input logic zx);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = v;
        w = s;
        return zx ? {16'b0, v} : w;
    endfunction

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select addressed lane, extend it, and build the merged store word
    always_comb begin
        byte_v = word[7:0];
        case (addr_lo)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];

        load_val = word;
        merged   = wdata;
        case (size)
            SZ_BYTE: begin
                load_val = ext8(byte_v, uns);
                merged   = word;
                case (addr_lo)
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    2'd3:    merged[31:24] = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                load_val = ext16(half_v, uns);
                merged   = word;
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: begin
                load_val = word;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side MIO bus initiator: one load/store per request, absorbs read
// latency of WAIT_CYCLES, optional sub-word access via read-modify-write
// when MEM_SUBWORD_EN is defined.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    mem_bus_if.master bus
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_r;
    logic [31:0]       addr_bus_r;
    logic [31:0]       data2bus_r;
    logic              misal_req;
    logic              sub_req;
    logic [31:0]       load_val;

`ifdef MEM_SUBWORD_EN
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] store_val;

    // Hold request fields the lane logic needs after the accept edge
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req) begin
            addr_lo_q <= bus.addr[1:0];
            size_q    <= bus.size;
            uns_q     <= bus.uns;
            wdata_q   <= bus.wdata;
        end
    end

    mem_lane_align u_lane (
        .word     (bus.Cpu_data4bus),
        .addr_lo  (addr_lo_q),
        .size     (size_q),
        .uns      (uns_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (store_val)
    );

    // Classify the incoming request; size 11 behaves as a word
    always_comb begin
        sub_req   = (bus.size == SZ_HALF) || (bus.size == SZ_BYTE);
        misal_req = (bus.addr[1:0] != 2'b00);
        if (bus.size == SZ_HALF)      misal_req = bus.addr[0];
        else if (bus.size == SZ_BYTE) misal_req = 1'b0;
    end
`else
    logic unused_sub;
    assign unused_sub = ^{bus.size, bus.uns};
    assign load_val   = bus.Cpu_data4bus;

    // Every access is a word access in this build
    always_comb begin
        sub_req   = 1'b0;
        misal_req = (bus.addr[1:0] != 2'b00);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (misal_req)    state_nx = ERR;
                    else if (!bus.we) state_nx = RD;
`ifdef MEM_SUBWORD_EN
                    else if (sub_req) state_nx = RMW_RD;
`endif
                    else              state_nx = WR;
                end
            end
            RD:      if (cnt == '0) state_nx = DONE;
`ifdef MEM_SUBWORD_EN
            RMW_RD:  if (cnt == '0) state_nx = WR;
`endif
            WR:      state_nx = DONE;
            ERR:     state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus address/data registers, wait counter and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r    <= '0;
            addr_bus_r <= '0;
            data2bus_r <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req && !misal_req) begin
                        addr_bus_r <= {bus.addr[31:2], 2'b00};
                        cnt        <= CNT_W'(WAIT_CYCLES);
                        if (bus.we && !sub_req) data2bus_r <= bus.wdata;
                    end
                end
                RD: begin
                    if (cnt == '0) rdata_r <= load_val;
                    else           cnt     <= cnt - 1'b1;
                end
`ifdef MEM_SUBWORD_EN
                RMW_RD: begin
                    if (cnt == '0) data2bus_r <= store_val;
                    else           cnt        <= cnt - 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.rdata        = rdata_r;
    assign bus.addr_bus     = addr_bus_r;
    assign bus.Cpu_data2bus = data2bus_r;
    assign bus.mem_w        = (state == WR);
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE) || (state == ERR);
    assign bus.misalign     = (state == ERR);

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master (WAIT_CYCLES=1); sub-word cases are
// selected by MEM_SUBWORD_EN, matching the design build.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int W = 1;

    logic clk = 1'b0;
    logic rst;

    mem_bus_if bus ();

    mem_bus_master #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_abus  = '0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        int          nw;
        logic [31:0] wd;
        logic [31:0] abus;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bw, input int lat, input logic [31:0] rd,
                          input logic mis, input logic [31:0] wd);
        exp_t e, o;
        int k, nw, wcyc;
        logic [31:0] gw, ga, ga1, grd;
        logic gmis, got_done;
        e.lat   = lat;
        e.mis   = mis;
        e.rdata = (!we && !mis) ? rd : last_rdata;
        e.nw    = (we && !mis) ? 1 : 0;
        e.wd    = wd;
        e.abus  = mis ? last_abus : {addr[31:2], 2'b00};
        sb.push_back(e);

        @(negedge clk);
        bus.we = we; bus.size = sz; bus.uns = uns;
        bus.addr = addr; bus.wdata = wdata; bus.Cpu_data4bus = bw;
        bus.req = 1'b1;
        @(posedge clk);
        k = 0; nw = 0; wcyc = 0; gw = '0; ga = '0; ga1 = '0; grd = '0;
        gmis = 1'b0; got_done = 1'b0;
        while (!got_done && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({tag, ":busy"}, {31'b0, bus.busy}, 32'd1);
                ga1 = bus.addr_bus;
            end
            if (bus.mem_w) begin
                nw++; wcyc = k; gw = bus.Cpu_data2bus; ga = bus.addr_bus;
            end
            if (bus.done) begin
                got_done = 1'b1; gmis = bus.misalign; grd = bus.rdata;
            end
            // Requests while busy or in the finishing cycle must be ignored
            bus.req = (k == 1) || bus.done;
        end
        o = sb.pop_front();
        check({tag, ":done"}, {31'b0, got_done}, 32'd1);
        check({tag, ":lat"}, k, o.lat);
        check({tag, ":mis"}, {31'b0, gmis}, {31'b0, o.mis});
        check({tag, ":rdata"}, grd, o.rdata);
        check({tag, ":abus"}, ga1, o.abus);
        check({tag, ":nwr"}, nw, o.nw);
        if (o.nw > 0) begin
            check({tag, ":wdata"}, gw, o.wd);
            check({tag, ":waddr"}, ga, o.abus);
            check({tag, ":wcyc"}, wcyc, o.lat - 1);
        end
        @(negedge clk);
        bus.req = 1'b0;
        check({tag, ":idle"}, {29'b0, bus.busy, bus.done, bus.mem_w}, 32'd0);
        last_rdata = o.rdata;
        if (!o.mis) last_abus = o.abus;
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.uns = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.Cpu_data4bus = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:rdata", bus.rdata, 32'd0);
        check("rst:addr_bus", bus.addr_bus, 32'd0);
        check("rst:data2bus", bus.Cpu_data2bus, 32'd0);
        check("rst:ctrl", {28'b0, bus.mem_w, bus.done, bus.misalign, bus.busy}, 32'd0);
        rst = 1'b0;

        access("ld_word",  1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, W + 2, 32'hDEAD_BEEF, 1'b0, 32'h0);
        access("st_word",  1'b1, SZ_WORD, 1'b0, 32'hE000_0000, 32'h1234_5678, 32'h0, 2, 32'h0, 1'b0, 32'h1234_5678);
        access("st_sz3",   1'b1, 2'b11,   1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 2, 32'h0, 1'b0, 32'hCAFE_F00D);
        access("ld_mis",   1'b0, SZ_WORD, 1'b0, 32'h0000_0102, 32'h0, 32'h5555_5555, 1, 32'h0, 1'b1, 32'h0);
`ifdef MEM_SUBWORD_EN
        access("ld_b3s",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_7F01, W + 2, 32'hFFFF_FF80, 1'b0, 32'h0);
        access("ld_b3u",   1'b0, SZ_BYTE, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_7F01, W + 2, 32'h0000_0080, 1'b0, 32'h0);
        access("ld_h2s",   1'b0, SZ_HALF, 1'b0, 32'h0000_0202, 32'h0, 32'h80FF_7F01, W + 2, 32'hFFFF_80FF, 1'b0, 32'h0);
        access("ld_h0u",   1'b0, SZ_HALF, 1'b1, 32'h0000_0200, 32'h0, 32'h80FF_7F01, W + 2, 32'h0000_7F01, 1'b0, 32'h0);
        access("ld_b1s",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0201, 32'h0, 32'h80FF_7F01, W + 2, 32'h0000_007F, 1'b0, 32'h0);
        access("ld_b2s",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0202, 32'h0, 32'h80FF_7F01, W + 2, 32'hFFFF_FFFF, 1'b0, 32'h0);
        access("st_b1",    1'b1, SZ_BYTE, 1'b0, 32'h0000_0301, 32'h9999_9911, 32'hAABB_CCDD, W + 3, 32'h0, 1'b0, 32'hAABB_11DD);
        access("st_h2",    1'b1, SZ_HALF, 1'b0, 32'h0000_0302, 32'h1234_5566, 32'hAABB_CCDD, W + 3, 32'h0, 1'b0, 32'h5566_CCDD);
        access("st_b0",    1'b1, SZ_BYTE, 1'b0, 32'h0000_0300, 32'h0000_00EE, 32'hAABB_CCDD, W + 3, 32'h0, 1'b0, 32'hAABB_CCEE);
        access("st_b3",    1'b1, SZ_BYTE, 1'b0, 32'h0000_0303, 32'h0000_00EE, 32'hAABB_CCDD, W + 3, 32'h0, 1'b0, 32'hEEBB_CCDD);
        access("st_h_mis", 1'b1, SZ_HALF, 1'b0, 32'h0000_0301, 32'h0000_1234, 32'hAABB_CCDD, 1, 32'h0, 1'b1, 32'h0);
        access("ld_h_mis", 1'b0, SZ_HALF, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 1, 32'h0, 1'b1, 32'h0);
`else
        access("ld_b3_mis", 1'b0, SZ_BYTE, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_7F01, 1, 32'h0, 1'b1, 32'h0);
        access("st_b1_mis", 1'b1, SZ_BYTE, 1'b0, 32'h0000_0301, 32'h11, 32'hAABB_CCDD, 1, 32'h0, 1'b1, 32'h0);
        access("ld_b0_wd",  1'b0, SZ_BYTE, 1'b0, 32'h0000_0200, 32'h0, 32'h80FF_7F01, W + 2, 32'h80FF_7F01, 1'b0, 32'h0);
        access("st_h0_wd",  1'b1, SZ_HALF, 1'b0, 32'h0000_0300, 32'h1234_5566, 32'hAABB_CCDD, 2, 32'h0, 1'b0, 32'h1234_5566);
`endif

        // Reset in the middle of a read phase
        @(negedge clk);
`ifdef MEM_SUBWORD_EN
        bus.we = 1'b1; bus.size = SZ_BYTE; bus.addr = 32'h0000_0301; bus.wdata = 32'h11;
`else
        bus.we = 1'b0; bus.size = SZ_WORD; bus.addr = 32'h0000_0100; bus.wdata = 32'h0;
`endif
        bus.Cpu_data4bus = 32'hAABB_CCDD;
        bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("mid:busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid:ctrl", {29'b0, bus.busy, bus.done, bus.mem_w}, 32'd0);
        check("mid:rdata", bus.rdata, 32'd0);
        check("mid:data2bus", bus.Cpu_data2bus, 32'd0);
        check("mid:addr_bus", bus.addr_bus, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid:quiet", {30'b0, bus.done, bus.mem_w}, 32'd0);
        end
        last_rdata = '0;
        last_abus  = '0;
        access("after_rst", 1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, W + 2, 32'h0BAD_F00D, 1'b0, 32'h0);
        access("after_st",  1'b1, SZ_WORD, 1'b0, 32'h0000_0108, 32'h7654_3210, 32'h0, 2, 32'h0, 1'b0, 32'h7654_3210);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side initiator for the MIO bus: turns one load/store request from the multi-cycle controller into a bus transaction on `addr_bus`/`Cpu_data2bus`/`mem_w`, and returns read data taken from `Cpu_data4bus`. It sits between the CPU datapath/controller and the address-decoding bus block that fans out to data RAM, the GPIO LEDs, the seven-segment display and the counter. It absorbs synchronous-RAM read latency and, optionally, performs sub-word access via read-modify-write.

## Interface
- `WAIT_CYCLES`, 1: read-data latency of the bus, in cycles; legal range 0–15.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: access request; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load; sampled with `req`.
- `size` in 2: 00 word, 01 half, 10 byte, 11 treated as word.
- `uns` in 1: 1 = zero-extend sub-word load, 0 = sign-extend.
- `addr` in 32: byte address, latched on accept.
- `wdata` in 32: store data, latched on accept; sub-word data is in the low bits.
- `rdata` out 32: load result; held until the next load completes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when an access finishes.
- `misalign` out 1: one-cycle pulse together with `done` on an aligned-access violation.
- `addr_bus` out 32: bus address, word aligned (`{addr[31:2],2'b00}`).
- `Cpu_data2bus` out 32: bus write data.
- `mem_w` out 1: bus write strobe.
- `Cpu_data4bus` in 32: bus read data.

## Operation
- States: IDLE, RD, RMW_RD, WR, ERR, DONE.
- IDLE → on `req`, latch `we`, `size`, `uns`, `addr` and `wdata`:
  - misaligned request → ERR; no bus activity.
  - load → RD.
  - store word → WR.
  - store half/byte → RMW_RD.
- Misaligned: word with `addr[1:0]`≠0; half with `addr[0]`=1.
- RD / RMW_RD:
  - drive `addr_bus` and load a wait counter with `WAIT_CYCLES`.
  - decrement the counter each cycle.
  - on the cycle the counter is 0, capture `Cpu_data4bus`.
  - RD → DONE. RMW_RD → WR.
- Load extraction is little-endian.
  - byte lane k = `addr[1:0]`, bits [8k+7:8k].
  - half lane = `addr[1]`.
  - extend to 32 bits per `uns`.
- RMW merge: replace only the addressed lane of the captured word with the low byte/half of `wdata`. All other lanes are preserved bit-exactly.
- WR: `mem_w`=1 for exactly one cycle, with `Cpu_data2bus` = the word (word store) or the merged word; then DONE.
- ERR: `done`=1 and `misalign`=1, `rdata` unchanged; then IDLE.
- DONE: `done`=1 for one cycle; then IDLE. A `req` high in this cycle is ignored.
- `req` while busy is ignored; requests are not queued.
- Reset values:
  - state IDLE.
  - `rdata`, `addr_bus`, `Cpu_data2bus` = 0.
  - `mem_w`, `done`, `misalign`, `busy` = 0.
- Between accesses `addr_bus` and `Cpu_data2bus` hold their last values; `mem_w` is 0 outside WR.

## Timing
- Request accepted at rising edge E0 (IDLE, `req`=1); `busy` is high from E0+1.
- Word/sub-word load: bus address valid from E0+1; `done` and valid `rdata` in cycle E0+`WAIT_CYCLES`+2.
- Word store: `mem_w` in cycle E0+1; `done` in E0+2.
- Sub-word store: `mem_w` in cycle E0+`WAIT_CYCLES`+2; `done` in E0+`WAIT_CYCLES`+3.
- Misaligned: `done`/`misalign` in cycle E0+1.
- `rst` asserted mid-access:
  - state is IDLE at the next edge.
  - `mem_w` drops at that edge and no `done` is generated.
  - a partially merged word is discarded.
- Back-to-back: a new `req` can be accepted in the cycle after DONE.

## Configuration
- `MEM_SUBWORD_EN` defined:
  - half/byte loads with extension, and RMW stores, as above.
- `MEM_SUBWORD_EN` undefined:
  - `size` and `uns` are ignored; every access is a word access.
  - state RMW_RD and the lane logic are not built.
  - misalign is flagged when `addr[1:0]`≠0.

## Structure
- Package `mem_bus_pkg`:
  - state enum.
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - wait-counter width constant (4).
- Sub-module `mem_lane_align` (combinational, built only under `MEM_SUBWORD_EN`): load-lane extract/extend and store-lane merge.

## Test plan
- `WAIT_CYCLES`=1, load word at 0x100 with bus returning 0xDEADBEEF → `done` at E0+3, `rdata`=0xDEADBEEF, `mem_w` never high.
- Store word 0x12345678 at 0xE0000000 → `mem_w`=1 only at E0+1 with `addr_bus`=0xE0000000 and `Cpu_data2bus`=0x12345678; `done` at E0+2.
- Bus word 0x80FF7F01:
  - load byte at addr 0x203, `uns`=0 → 0xFFFFFF80.
  - load byte at addr 0x203, `uns`=1 → 0x00000080.
  - load half at addr 0x202, `uns`=0 → 0xFFFF80FF.
- RMW: bus word 0xAABBCCDD, store byte 0x11 at addr 0x301 → single `mem_w` with `Cpu_data2bus`=0xAABB11DD; `done` at E0+4.
- Load word at 0x102 → `done`+`misalign` at E0+1, no bus write, `rdata` unchanged.
- `rst` asserted in RMW_RD → IDLE next edge, no `mem_w`, no `done`; a following `req` is accepted normally.
